// File: rtl/mdu_rs_if.sv
`default_nettype none
// ============================================================================
// mdu_rs_pkg / mdu_rs_if
// Micro-op and writeback types plus the dispatch/CDB/issue bundle for mdu_rs.
// Revision: 1.0
// ============================================================================
package mdu_rs_pkg;
    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic             is_renamed;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } operand_t;

    typedef struct packed {
        logic             is_valid;
        logic [2:0]       op;
        logic [TAG_W-1:0] dest_tag;
        operand_t         src_0_a;
        operand_t         src_0_b;
    } instruction_t;

    typedef struct packed {
        logic             is_valid;
        logic [TAG_W-1:0] dest_tag;
        logic [XLEN-1:0]  result;
    } writeback_packet_t;
endpackage

interface mdu_rs_if #(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 2
);
    import mdu_rs_pkg::*;

    instruction_t                          rs_alloc_packet;
    logic                                  rs_alloc_rdy;
    writeback_packet_t [NUM_CDB-1:0]       cdb_ports;
    logic                                  mdu_rdy;
    instruction_t                          mdu_packet;
    logic [$clog2(DEPTH+1)-1:0]            rs_count;

    modport master (
        output rs_alloc_packet, cdb_ports, mdu_rdy,
        input  rs_alloc_rdy, mdu_packet, rs_count
    );

    modport slave (
        input  rs_alloc_packet, cdb_ports, mdu_rdy,
        output rs_alloc_rdy, mdu_packet, rs_count
    );
endinterface
`default_nettype wire

// File: rtl/mdu_rs.sv
`default_nettype none
// ============================================================================
// mdu_rs
// Age-ordered collapsing reservation station feeding the multiply/divide unit.
// Revision: 1.0
// ============================================================================
module mdu_rs
    import mdu_rs_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic flush,
    mdu_rs_if.slave   rs
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    instruction_t     r_entry [DEPTH];
    logic [CNT_W-1:0] r_count;

    instruction_t     w_woken [DEPTH];
    instruction_t     w_shift [DEPTH];
    instruction_t     w_next  [DEPTH];
    instruction_t     w_alloc_pkt;
    logic [DEPTH-1:0] w_ready;
    logic [IDX_W-1:0] w_sel;
    logic             w_any_ready;
    logic             w_issue;
    logic             w_alloc;
    logic             w_rdy;
    logic [CNT_W-1:0] w_slot;
    logic [CNT_W-1:0] w_count_next;

    // Lowest-index matching port wins: once cleared, later ports cannot match.
    function automatic operand_t wake_operand(input operand_t opnd,
                                              input writeback_packet_t [NUM_CDB-1:0] cdb);
        operand_t res;
        res = opnd;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (res.is_renamed && cdb[p].is_valid && (cdb[p].dest_tag == res.tag)) begin
                res.data       = cdb[p].result;
                res.is_renamed = 1'b0;
            end
        end
        return res;
    endfunction

    function automatic instruction_t wake_entry(input instruction_t ent,
                                                input writeback_packet_t [NUM_CDB-1:0] cdb);
        instruction_t res;
        res         = ent;
        res.src_0_a = wake_operand(ent.src_0_a, cdb);
        res.src_0_b = wake_operand(ent.src_0_b, cdb);
        return res;
    endfunction

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            assign w_woken[i] = wake_entry(r_entry[i], rs.cdb_ports);
            // Readiness uses registered operands only, so a wakeup issues no earlier than the next cycle.
            assign w_ready[i] = r_entry[i].is_valid
                              && !r_entry[i].src_0_a.is_renamed
                              && !r_entry[i].src_0_b.is_renamed;
            if (i < DEPTH - 1) begin : g_shift
                assign w_shift[i] = w_woken[i+1];
            end else begin : g_top
                assign w_shift[i] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_sel       = '0;
        w_any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel       = IDX_W'(i);
                w_any_ready = 1'b1;
            end
        end
    end

    assign w_rdy       = (r_count < CNT_W'(DEPTH));
    assign w_issue     = rs.mdu_rdy && w_any_ready && !flush;
    assign w_alloc     = rs.rs_alloc_packet.is_valid && w_rdy && !flush;
    assign w_alloc_pkt = wake_entry(rs.rs_alloc_packet, rs.cdb_ports);
    assign w_slot      = r_count - CNT_W'(w_issue);

    assign rs.rs_alloc_rdy = w_rdy;
    assign rs.mdu_packet   = w_issue ? r_entry[w_sel] : '0;
    assign rs.rs_count     = r_count;

    // Invalid slots are kept all-zero so shifting in from above needs no masking.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = (w_issue && (IDX_W'(i) >= w_sel)) ? w_shift[i] : w_woken[i];
            if (w_alloc && (CNT_W'(i) == w_slot)) begin
                w_next[i] = w_alloc_pkt;
            end
            if (flush) begin
                w_next[i] = '0;
            end
        end
    end

    assign w_count_next = flush ? '0 : (r_count + CNT_W'(w_alloc) - CNT_W'(w_issue));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_next[i];
            end
            r_count <= w_count_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mdu_rs.sv
`default_nettype none
// ============================================================================
// tb_mdu_rs
// Directed and random checks of mdu_rs against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_mdu_rs;
    import mdu_rs_pkg::*;

    localparam int DEPTH   = 4;
    localparam int NUM_CDB = 2;
    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_DIV = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    mdu_rs_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) bus ();

    mdu_rs #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .rs    (bus)
    );

    instruction_t q[$];
    int           n_vec  = 0;
    int           n_fail = 0;
    instruction_t obs_pkt;
    logic         obs_rdy;
    logic [2:0]   obs_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instruction_t mk(input logic [2:0] op, input logic [TAG_W-1:0] dest,
                                        input logic ar, input logic [TAG_W-1:0] at, input logic [31:0] ad,
                                        input logic br, input logic [TAG_W-1:0] bt, input logic [31:0] bd);
        instruction_t p;
        p.is_valid = 1'b1;
        p.op       = op;
        p.dest_tag = dest;
        p.src_0_a  = '{is_renamed: ar, tag: at, data: ad};
        p.src_0_b  = '{is_renamed: br, tag: bt, data: bd};
        return p;
    endfunction

    function automatic operand_t wk(input operand_t o);
        for (int p = 0; p < NUM_CDB; p++) begin
            if (o.is_renamed && bus.cdb_ports[p].is_valid && bus.cdb_ports[p].dest_tag == o.tag) begin
                o.data       = bus.cdb_ports[p].result;
                o.is_renamed = 1'b0;
            end
        end
        return o;
    endfunction

    function automatic instruction_t wk_ins(input instruction_t e);
        e.src_0_a = wk(e.src_0_a);
        e.src_0_b = wk(e.src_0_b);
        return e;
    endfunction

    task automatic idle();
        bus.rs_alloc_packet = '0;
        bus.cdb_ports       = '0;
        flush               = 1'b0;
    endtask

    task automatic set_cdb(input int p, input logic [TAG_W-1:0] tag, input logic [31:0] res);
        bus.cdb_ports[p].is_valid = 1'b1;
        bus.cdb_ports[p].dest_tag = tag;
        bus.cdb_ports[p].result   = res;
    endtask

    // Called at posedge+1 with inputs set; checks mid-cycle, then advances the model at the edge.
    task automatic cycle();
        int           sel;
        bit           exp_iss;
        bit           accept;
        instruction_t exp_pkt;
        #4;
        sel = -1;
        foreach (q[i]) begin
            if (sel < 0 && !q[i].src_0_a.is_renamed && !q[i].src_0_b.is_renamed) sel = i;
        end
        exp_iss = bus.mdu_rdy && (sel >= 0) && !flush;
        exp_pkt = exp_iss ? q[sel] : '0;
        chk("alloc_rdy", bus.rs_alloc_rdy, q.size() < DEPTH);
        chk("rs_count", bus.rs_count, q.size());
        chk("mdu_packet", bus.mdu_packet, exp_pkt);
        obs_pkt = bus.mdu_packet;
        obs_rdy = bus.rs_alloc_rdy;
        obs_cnt = bus.rs_count;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            accept = bus.rs_alloc_packet.is_valid && (q.size() < DEPTH);
            if (exp_iss) q.delete(sel);
            foreach (q[i]) q[i] = wk_ins(q[i]);
            if (accept) q.push_back(wk_ins(bus.rs_alloc_packet));
        end
        #1;
    endtask

    task automatic drain();
        idle();
        bus.mdu_rdy = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
        chk("drain_empty", bus.rs_count, 0);
    endtask

    initial begin
        instruction_t pk;
        idle();
        bus.mdu_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", bus.rs_count, 0);
        chk("reset_rdy", bus.rs_alloc_rdy, 1);
        chk("reset_issue", bus.mdu_packet.is_valid, 0);
        rst = 1'b1;

        // Ready MUL issues one cycle after allocation
        bus.rs_alloc_packet = mk(OP_MUL, 9, 0, 0, 3, 0, 0, 5);
        cycle();
        chk("t1_cnt0", obs_cnt, 0);
        idle();
        cycle();
        chk("t1_valid", obs_pkt.is_valid, 1);
        chk("t1_a", obs_pkt.src_0_a.data, 3);
        chk("t1_b", obs_pkt.src_0_b.data, 5);
        chk("t1_dest", obs_pkt.dest_tag, 9);
        chk("t1_cnt1", obs_cnt, 1);
        cycle();
        chk("t1_cnt2", obs_cnt, 0);

        // DIV waits for tag 7 broadcast on port 1
        bus.rs_alloc_packet = mk(OP_DIV, 20, 0, 0, 100, 1, 7, 0);
        cycle();
        idle();
        cycle();
        chk("t2_wait1", obs_pkt.is_valid, 0);
        set_cdb(1, 7, 3);
        cycle();
        chk("t2_wait2", obs_pkt.is_valid, 0);
        idle();
        cycle();
        chk("t2_valid", obs_pkt.is_valid, 1);
        chk("t2_b", obs_pkt.src_0_b.data, 3);
        chk("t2_dest", obs_pkt.dest_tag, 20);

        // Wakeup in the dispatch cycle
        bus.rs_alloc_packet = mk(OP_MUL, 21, 1, 4, 0, 0, 0, 6);
        set_cdb(0, 4, 32'hA);
        cycle();
        idle();
        cycle();
        chk("t3_valid", obs_pkt.is_valid, 1);
        chk("t3_a", obs_pkt.src_0_a.data, 32'hA);
        drain();

        // Age order with the oldest entry pending
        bus.mdu_rdy = 1'b0;
        bus.rs_alloc_packet = mk(OP_MUL, 10, 1, 5, 0, 0, 0, 1);
        cycle();
        for (int k = 0; k < 3; k++) begin
            bus.rs_alloc_packet = mk(OP_MUL, TAG_W'(11 + k), 0, 0, k, 0, 0, 2);
            cycle();
        end
        idle();
        bus.mdu_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_order", obs_pkt.dest_tag, 11 + k);
        end
        set_cdb(0, 5, 32'h55);
        cycle();
        chk("t4_wait", obs_pkt.is_valid, 0);
        idle();
        cycle();
        chk("t4_last", obs_pkt.dest_tag, 10);
        chk("t4_a", obs_pkt.src_0_a.data, 32'h55);

        // Full: fifth dispatch dropped, held dispatch accepted after first issue
        bus.mdu_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.rs_alloc_packet = mk(OP_MUL, TAG_W'(30 + k), 0, 0, 1, 0, 0, 1);
            cycle();
        end
        bus.rs_alloc_packet = mk(OP_DIV, 34, 0, 0, 7, 0, 0, 7);
        cycle();
        chk("t5_full_rdy", obs_rdy, 0);
        chk("t5_full_cnt", obs_cnt, 4);
        bus.mdu_rdy = 1'b1;
        cycle();
        chk("t5_issue", obs_pkt.dest_tag, 30);
        chk("t5_nobypass", obs_rdy, 0);
        cycle();
        chk("t5_accept", obs_rdy, 1);
        drain();

        // Flush suppresses issue and allocation
        bus.mdu_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.rs_alloc_packet = mk(OP_MUL, TAG_W'(40 + k), 0, 0, 2, 0, 0, 2);
            cycle();
        end
        bus.rs_alloc_packet = mk(OP_MUL, 43, 0, 0, 4, 0, 0, 4);
        bus.mdu_rdy = 1'b1;
        flush = 1'b1;
        cycle();
        chk("t6_noissue", obs_pkt.is_valid, 0);
        chk("t6_cnt3", obs_cnt, 3);
        idle();
        cycle();
        chk("t6_cnt0", obs_cnt, 0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            pk = mk(3'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 63)),
                    $urandom_range(0, 2) == 0, TAG_W'($urandom_range(1, 6)), $urandom,
                    $urandom_range(0, 2) == 0, TAG_W'($urandom_range(1, 6)), $urandom);
            pk.is_valid = ($urandom_range(0, 9) < 6);
            bus.rs_alloc_packet = pk;
            for (int p = 0; p < NUM_CDB; p++) begin
                bus.cdb_ports[p].is_valid = ($urandom_range(0, 2) == 0);
                bus.cdb_ports[p].dest_tag = TAG_W'($urandom_range(1, 6));
                bus.cdb_ports[p].result   = $urandom;
            end
            bus.mdu_rdy = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 49) == 0);
            cycle();
        end

        // Asynchronous reset with ready entries resident
        idle();
        bus.mdu_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.rs_alloc_packet = mk(OP_MUL, TAG_W'(50 + k), 0, 0, 1, 0, 0, 1);
            cycle();
        end
        idle();
        bus.mdu_rdy = 1'b1;
        rst = 1'b0;
        #1;
        chk("arst_cnt", bus.rs_count, 0);
        chk("arst_issue", bus.mdu_packet.is_valid, 0);
        chk("arst_rdy", bus.rs_alloc_rdy, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.rs_alloc_packet = mk(OP_MUL, 60, 0, 0, 8, 0, 0, 9);
        cycle();
        idle();
        cycle();
        chk("post_arst_issue", obs_pkt.dest_tag, 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mdu_rs.md
# mdu_rs

Reservation station and issue scheduler for the shared multiply/divide unit (`mdu`). It buffers up to `DEPTH` M-extension micro-ops from dispatch and captures missing operands from the CDB broadcast ports. Each cycle that `mdu` is ready, it issues the oldest micro-op whose operands are both available. It sits between the dispatch/rename stage and `mdu`, and is the only driver of `mdu_packet`.

## Interface
- `DEPTH`, 4: number of entries, minimum 2.
- `NUM_CDB`, 2: number of CDB broadcast ports snooped for wakeup.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `flush`  in  1  synchronous pipeline flush; clears every entry.
- `rs_alloc_packet`  in  `instruction_t`  dispatched micro-op; `is_valid` requests allocation.
- `rs_alloc_rdy`  out  1  space available: `count < DEPTH`.
- `cdb_ports`  in  `writeback_packet_t [NUM_CDB]`  broadcast results (`is_valid`, `dest_tag`, `result`).
- `mdu_rdy`  in  1  `mdu` can accept a micro-op this cycle.
- `mdu_packet`  out  `instruction_t`  issued micro-op; `is_valid` qualifies.
- `rs_count`  out  `$clog2(DEPTH+1)`  number of occupied entries.

## Operation
- Operand encoding:
  - `src_x.is_renamed=1`: the operand is pending, and its producer tag is in `src_x.tag`.
  - `src_x.is_renamed=0`: `src_x.data` is final.
- Storage is a collapsing queue in age order. Entry 0 is the oldest. Valid entries are contiguous from 0.
- Allocation:
  - Occurs when `rs_alloc_packet.is_valid && rs_alloc_rdy && !flush`.
  - The packet is written to the first free slot after any issue-collapse in the same cycle.
  - Dispatch that does not meet these conditions is dropped. Dispatch must hold the packet until `rs_alloc_rdy` is high.
- Wakeup:
  - Each cycle, every pending operand of every valid entry is compared with every CDB port where `is_valid=1`.
  - On a `dest_tag` match, the operand is written as `data<=result` and `is_renamed<=0`.
  - The incoming allocation packet is compared with the CDB ports in the same way, so a producer broadcasting in the dispatch cycle is not missed.
  - If more than one port matches the same operand, the lowest-index port wins; this condition does not arise in normal operation.
- Ready: an entry is ready when it is valid and both `src_0_a.is_renamed` and `src_0_b.is_renamed` are 0, as held in the registered state.
- Select and issue:
  - `mdu_packet` is combinational from the lowest-index ready entry.
  - `mdu_packet.is_valid = mdu_rdy && any_ready && !flush`.
  - On that clock edge, the issued entry is removed and entries above it shift down by one.
  - At most one issue per cycle.
- When `mdu_packet.is_valid=0`, the other fields of `mdu_packet` are don't-care and are driven to `'0`.
- Flush: all entries are invalidated at the next edge. In the flush cycle, allocation and issue are both suppressed.
- `rs_count` is next-state accurate: +1 on allocation, −1 on issue, net 0 when both occur.

## Timing
- Reset (`rst=0`, asynchronous): all entries invalid, `rs_count=0`, `rs_alloc_rdy=1`, `mdu_packet.is_valid=0`. The block leaves reset on the first edge after `rst=1`.
- Alloc-to-issue latency:
  - Operands ready at dispatch, or woken by the CDB in the dispatch cycle: issue is possible 1 cycle after allocation.
  - Operand woken while the entry is resident: issue is possible in the cycle after the wakeup edge. There is no same-cycle wakeup-to-issue bypass.
- When full (`rs_count=DEPTH`), `rs_alloc_rdy=0` even if an issue happens that cycle; there is no full-bypass. Allocation resumes the cycle after `count` drops.
- Simultaneous allocation and issue when `count=DEPTH-1`: both occur, and `count` remains `DEPTH-1`.
- `mdu_rdy` is trusted as-is; `mdu` deasserts it while busy. `mdu_rdy=0` holds all entries except for wakeup updates.
- An asynchronous reset mid-operation discards all entries immediately, including an entry being issued in that cycle.

## Test plan
- Reset, then dispatch MUL with rs1=3 and rs2=5, both not renamed, with `mdu_rdy=1`. Required:
  - `mdu_packet.is_valid=1` one cycle after the alloc edge, carrying data 3/5 and the same `dest_tag`.
  - `rs_count` goes 0→1→0.
- Dispatch DIV with `src_0_b` renamed to tag 7, then drive CDB port 1 with `dest_tag=7` and `result=3` two cycles later. Required:
  - no issue before the wakeup;
  - issue in the cycle after the wakeup edge with `src_0_b.data=3`.
- Same-cycle dispatch wakeup: dispatch with `src_0_a` pending on tag 4 while CDB port 0 broadcasts tag 4 with result 0xA. Required: the next cycle issues with `src_0_a.data=0xA`.
- Age order: fill 4 entries with A (pending), B, C, D (ready), then wake A. Required:
  - B, C and D issue in order first;
  - A issues after its wakeup.
- With `mdu_rdy=0`, fill to 4. Required: `rs_alloc_rdy=0` and a fifth dispatch is dropped. Then raise `mdu_rdy` and hold a new dispatch. Required: the new dispatch is accepted one cycle after the first issue.
- With 3 entries resident, assert `flush` for one cycle while an allocation and a ready issue are both present. Required: no issue that cycle, `rs_count=0` next cycle, and the allocation is discarded.
